ram_arbiter: RTL

Round-robin arbiter and sequencer for the board's 32×8 single-port synchronous RAM (registered read, write-enable, shared address). It lets two requesters (for example a switch/KEY front-end and an autonomous pattern engine) share that RAM with a valid/ready handshake. It returns read data through per-requester response strobes and can optionally zero the whole array after reset. It sits between the requesters and the RAM instance at the top level.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 16 +
 rtl/ram_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default geometry for the RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 32;

    // CLEAR zeroes the array; RUN arbitrates requester traffic.
    typedef enum logic {
        StClear,
        StRun
    } state_e;

    // Rides alongside a command until its response strobe fires.
    typedef struct packed {
        logic valid;
        logic idx;
    } tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker. Grant is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // A lone requester wins outright; on a tie the one not granted last time wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous RAM
// between two valid/ready requesters. Read data returns two cycles after
// acceptance on per-requester response strobes (read-before-write).
// Optional post-reset / on-demand array clear is compiled in when the
// RAM_ARB_CLEAR_EN macro is defined; without it the block starts in RUN,
// busy is 0 and clear is ignored.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF    // must equal 2**ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    input  logic              clear,
    output logic              busy,
    output logic              last_grant,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            state_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              mem_wren_q;
    tag_t              tag_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;

    logic              run_ok;
    logic [1:0]        req_valid;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;

`ifdef RAM_ARB_CLEAR_EN
    logic [ADDR_W-1:0] cnt_q;

    // A clear pulse blocks acceptance so the two can never collide.
    assign run_ok = (state_q == StRun) && !clear;
`else
    logic unused_clear;

    assign unused_clear = clear;
    assign run_ok       = 1'b1;
`endif

    assign req_valid = {req1_valid, req0_valid} & {2{run_ok}};

    rr_pick2 u_pick (
        .valid (req_valid),
        .last  (last_grant_q),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;
    assign sel        = grant[1];

    // Sequencer FSM: clear walk, arbitration bookkeeping and registered RAM port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
`ifdef RAM_ARB_CLEAR_EN
            state_q <= StClear;
            cnt_q   <= '0;
`else
            state_q <= StRun;
`endif
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_wren_q   <= 1'b0;
        end else begin
            mem_wren_q <= 1'b0;
            case (state_q)
                StClear: begin
`ifdef RAM_ARB_CLEAR_EN
                    mem_addr_q <= cnt_q;
                    mem_din_q  <= '0;
                    mem_wren_q <= 1'b1;
                    cnt_q      <= cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= StRun;
                    end
`endif
                end
                StRun: begin
`ifdef RAM_ARB_CLEAR_EN
                    if (clear) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
`endif
                    if (accept) begin
                        last_grant_q <= sel;
                        mem_addr_q   <= sel ? req1_addr : req0_addr;
                        mem_din_q    <= sel ? req1_wdata : req0_wdata;
                        mem_wren_q   <= sel ? req1_we : req0_we;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-stage tag pipeline; keeps running through a clear so in-flight reads finish.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            tag_q.valid  <= accept;
            tag_q.idx    <= sel;
            rsp0_valid_q <= tag_q.valid && !tag_q.idx;
            rsp1_valid_q <= tag_q.valid && tag_q.idx;
        end
    end

    assign busy       = (state_q == StClear);
    assign last_grant = last_grant_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_wren   = mem_wren_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = mem_dout;
    assign rsp1_rdata = mem_dout;

endmodule
